line_tracker: RTL and testbench

- Parametrised successor to the two-sensor route steering block in the CAR line-follower.
- Takes an NSENS-wide IR sensor bar, deglitches it, and drives the 4-bit motor enable bus through a mode FSM with five modes: idle, start delay, line following, lost-line search, and finish/fault stop.
- Sits between the sensor pins and the motor driver; the external start-delay counter input is replaced by an internal counter.

---
 rtl/line_tracker.sv | 186 ++++++++++++++++++
 tb/tb_line_tracker.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_tracker.sv
// Line-follower steering: deglitches an NSENS-wide IR sensor bar and drives the
// 4-bit motor enable bus through an idle/start/follow/search/done/fault mode FSM.
module line_tracker #(
    parameter int unsigned NSENS        = 4,
    parameter int unsigned START_DLY    = 10,
    parameter int unsigned FILT         = 3,
    parameter int unsigned FINISH_CNT   = 4,
    parameter int unsigned LOST_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [NSENS-1:0] din,
    output logic [3:0]       en,
    output logic [2:0]       state,
    output logic             fault
);

    localparam int unsigned HALF = NSENS / 2;
    localparam int unsigned PW   = $clog2(HALF + 1);
    localparam int unsigned FW   = $clog2(FILT + 1);
    localparam int unsigned DW   = $clog2(START_DLY + 1);
    localparam int unsigned NW   = $clog2(FINISH_CNT + 1);
    localparam int unsigned TW   = $clog2(LOST_TIMEOUT + 1);

    localparam logic [3:0] EN_STOP  = 4'b1111;
    localparam logic [3:0] EN_FWD   = 4'b1010;
    localparam logic [3:0] EN_LEFT  = 4'b1110;
    localparam logic [3:0] EN_RIGHT = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_FOLLOW = 3'd2,
        S_SEARCH = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           state_q;
    logic [3:0]       en_q;
    logic             fault_q;
    logic [3:0]       last_dir_q;
    logic [DW-1:0]    dly_q;
    logic [NW-1:0]    fin_q;
    logic [TW-1:0]    to_q;

    logic [NSENS-1:0] din_q;
    logic [NSENS-1:0] filt_q;
    logic [FW-1:0]    fcnt_q;

    logic [PW-1:0]    lcnt;
    logic [PW-1:0]    rcnt;
    logic [3:0]       dir;
    logic             none;
    logic             all_on;

    // fcnt_q counts consecutive identical samples held in din_q; filt loads once FILT are seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q  <= '0;
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            din_q <= din;
            if (din != din_q) begin
                fcnt_q <= FW'(1);
            end else if (fcnt_q != FW'(FILT)) begin
                fcnt_q <= fcnt_q + FW'(1);
            end
            if (fcnt_q == FW'(FILT)) begin
                filt_q <= din_q;
            end
        end
    end

    always_comb begin
        lcnt = '0;
        rcnt = '0;
        for (int unsigned i = 0; i < HALF; i++) begin
            rcnt = rcnt + PW'(filt_q[i]);
            lcnt = lcnt + PW'(filt_q[i+HALF]);
        end
        none   = (filt_q == '0);
        all_on = &filt_q;
        if (lcnt > rcnt) begin
            dir = EN_LEFT;
        end else if (rcnt > lcnt) begin
            dir = EN_RIGHT;
        end else begin
            dir = EN_FWD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= EN_STOP;
            fault_q    <= 1'b0;
            last_dir_q <= EN_FWD;
            dly_q      <= '0;
            fin_q      <= '0;
            to_q       <= '0;
        end else if (!run && (state_q == S_START || state_q == S_FOLLOW ||
                              state_q == S_SEARCH || state_q == S_FAULT)) begin
            state_q <= S_IDLE;
            en_q    <= EN_STOP;
            fault_q <= 1'b0;
            dly_q   <= '0;
            fin_q   <= '0;
            to_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q    <= EN_STOP;
                    fault_q <= 1'b0;
                    if (run) begin
                        state_q <= S_START;
                        dly_q   <= '0;
                    end
                end
                S_START: begin
                    if (dly_q == DW'(START_DLY - 1)) begin
                        state_q <= S_FOLLOW;
                        fin_q   <= '0;
                        if (none) begin
                            en_q <= last_dir_q;
                        end else begin
                            en_q       <= dir;
                            last_dir_q <= dir;
                        end
                    end else begin
                        dly_q <= dly_q + DW'(1);
                    end
                end
                S_FOLLOW: begin
                    if (all_on && fin_q == NW'(FINISH_CNT - 1)) begin
                        state_q <= S_DONE;
                        en_q    <= EN_STOP;
                    end else if (none) begin
                        state_q <= S_SEARCH;
                        en_q    <= last_dir_q;
                        to_q    <= '0;
                        fin_q   <= '0;
                    end else begin
                        en_q       <= dir;
                        last_dir_q <= dir;
                        fin_q      <= all_on ? fin_q + NW'(1) : '0;
                    end
                end
                S_SEARCH: begin
                    if (!none) begin
                        state_q    <= S_FOLLOW;
                        en_q       <= dir;
                        last_dir_q <= dir;
                        fin_q      <= '0;
                    end else if (to_q == TW'(LOST_TIMEOUT - 1)) begin
                        state_q <= S_FAULT;
                        en_q    <= EN_STOP;
                        fault_q <= 1'b1;
                    end else begin
                        to_q <= to_q + TW'(1);
                        en_q <= last_dir_q;
                    end
                end
                S_DONE: begin
                    en_q <= EN_STOP;
                end
                S_FAULT: begin
                    en_q    <= EN_STOP;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= EN_STOP;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign en    = en_q;
    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_line_tracker.sv
// Directed self-checking bench for line_tracker with hand-computed expectations.
module tb_line_tracker;

    localparam logic [3:0] STOP  = 4'b1111;
    localparam logic [3:0] FWD   = 4'b1010;
    localparam logic [3:0] LEFT  = 4'b1110;
    localparam logic [3:0] RIGHT = 4'b1011;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_FOLLOW = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] din;
    logic [3:0] en;
    logic [2:0] state;
    logic       fault;

    int nvec;
    int nerr;

    line_tracker #(
        .NSENS       (4),
        .START_DLY   (10),
        .FILT        (3),
        .FINISH_CNT  (4),
        .LOST_TIMEOUT(20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .din  (din),
        .en   (en),
        .state(state),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run   = 1'b0;
        din   = 4'b0000;
        tick();
        tick();
        nvec++;
        if ({state, en, fault} !== {S_IDLE, STOP, 1'b0}) begin
            nerr++;
            $display("FAIL reset: got state=%0d en=%b fault=%b, want state=0 en=1111 fault=0",
                     state, en, fault);
        end
    endtask

    task automatic test_start_delay;
        rst_n = 1'b1;
        run   = 1'b1;
        din   = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_START, STOP}) begin
                nerr++;
                $display("FAIL start_delay[%0d]: got state=%0d en=%b, want state=1 en=1111",
                         i, state, en);
            end
        end
        tick();
        nvec++;
        if ({state, en, fault} !== {S_FOLLOW, FWD, 1'b0}) begin
            nerr++;
            $display("FAIL start_to_follow: got state=%0d en=%b fault=%b, want state=2 en=1010 fault=0",
                     state, en, fault);
        end
    endtask

    task automatic test_steering;
        din = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_FOLLOW, FWD}) begin
                nerr++;
                $display("FAIL left_latency[%0d]: got state=%0d en=%b, want state=2 en=1010",
                         i, state, en);
            end
        end
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, LEFT}) begin
            nerr++;
            $display("FAIL left: got state=%0d en=%b, want state=2 en=1110", state, en);
        end

        din = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if (en !== LEFT) begin
                nerr++;
                $display("FAIL right_latency[%0d]: got en=%b, want en=1110", i, en);
            end
        end
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, RIGHT}) begin
            nerr++;
            $display("FAIL right: got state=%0d en=%b, want state=2 en=1011", state, en);
        end

        din = 4'b0001;
        tick();
        din = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_FOLLOW, RIGHT}) begin
                nerr++;
                $display("FAIL glitch[%0d]: got state=%0d en=%b, want state=2 en=1011",
                         i, state, en);
            end
        end

        din = 4'b1100;
        repeat (5) tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, LEFT}) begin
            nerr++;
            $display("FAIL left_again: got state=%0d en=%b, want state=2 en=1110", state, en);
        end
    endtask

    task automatic test_search_return;
        din = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_FOLLOW, LEFT}) begin
                nerr++;
                $display("FAIL lost_latency[%0d]: got state=%0d en=%b, want state=2 en=1110",
                         i, state, en);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_SEARCH, LEFT}) begin
                nerr++;
                $display("FAIL search_left[%0d]: got state=%0d en=%b, want state=3 en=1110",
                         i, state, en);
            end
        end
        din = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_SEARCH, LEFT}) begin
                nerr++;
                $display("FAIL reacquire_latency[%0d]: got state=%0d en=%b, want state=3 en=1110",
                         i, state, en);
            end
        end
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, FWD}) begin
            nerr++;
            $display("FAIL reacquire: got state=%0d en=%b, want state=2 en=1010", state, en);
        end
    endtask

    task automatic test_timeout_fault;
        din = 4'b0000;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            nvec++;
            if ({state, en, fault} !== {S_SEARCH, FWD, 1'b0}) begin
                nerr++;
                $display("FAIL search_fwd[%0d]: got state=%0d en=%b fault=%b, want state=3 en=1010 fault=0",
                         i, state, en, fault);
            end
        end
        tick();
        nvec++;
        if ({state, en, fault} !== {S_FAULT, STOP, 1'b1}) begin
            nerr++;
            $display("FAIL timeout: got state=%0d en=%b fault=%b, want state=5 en=1111 fault=1",
                     state, en, fault);
        end
        repeat (3) tick();
        nvec++;
        if ({state, en, fault} !== {S_FAULT, STOP, 1'b1}) begin
            nerr++;
            $display("FAIL fault_hold: got state=%0d en=%b fault=%b, want state=5 en=1111 fault=1",
                     state, en, fault);
        end
        run = 1'b0;
        tick();
        nvec++;
        if ({state, en, fault} !== {S_IDLE, STOP, 1'b0}) begin
            nerr++;
            $display("FAIL fault_clear: got state=%0d en=%b fault=%b, want state=0 en=1111 fault=0",
                     state, en, fault);
        end
    endtask

    task automatic test_finish;
        run = 1'b1;
        din = 4'b0110;
        repeat (11) tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, FWD}) begin
            nerr++;
            $display("FAIL finish_setup: got state=%0d en=%b, want state=2 en=1010", state, en);
        end
        din = 4'b1111;
        repeat (3) tick();
        din = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_FOLLOW, FWD}) begin
                nerr++;
                $display("FAIL short_all_on[%0d]: got state=%0d en=%b, want state=2 en=1010",
                         i, state, en);
            end
        end
        din = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_FOLLOW, FWD}) begin
                nerr++;
                $display("FAIL finish_count[%0d]: got state=%0d en=%b, want state=2 en=1010",
                         i, state, en);
            end
        end
        tick();
        nvec++;
        if ({state, en, fault} !== {S_DONE, STOP, 1'b0}) begin
            nerr++;
            $display("FAIL done: got state=%0d en=%b fault=%b, want state=4 en=1111 fault=0",
                     state, en, fault);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_DONE, STOP}) begin
                nerr++;
                $display("FAIL done_run0[%0d]: got state=%0d en=%b, want state=4 en=1111",
                         i, state, en);
            end
        end
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_DONE, STOP}) begin
                nerr++;
                $display("FAIL done_run1[%0d]: got state=%0d en=%b, want state=4 en=1111",
                         i, state, en);
            end
        end
        rst_n = 1'b0;
        tick();
        nvec++;
        if ({state, en, fault} !== {S_IDLE, STOP, 1'b0}) begin
            nerr++;
            $display("FAIL done_reset: got state=%0d en=%b fault=%b, want state=0 en=1111 fault=0",
                     state, en, fault);
        end
    endtask

    task automatic test_reset_midrun;
        rst_n = 1'b1;
        run   = 1'b1;
        din   = 4'b1100;
        repeat (10) tick();
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, LEFT}) begin
            nerr++;
            $display("FAIL midrun_setup: got state=%0d en=%b, want state=2 en=1110", state, en);
        end
        rst_n = 1'b0;
        tick();
        nvec++;
        if ({state, en, fault} !== {S_IDLE, STOP, 1'b0}) begin
            nerr++;
            $display("FAIL midrun_reset: got state=%0d en=%b fault=%b, want state=0 en=1111 fault=0",
                     state, en, fault);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if ({state, en} !== {S_START, STOP}) begin
                nerr++;
                $display("FAIL restart_delay[%0d]: got state=%0d en=%b, want state=1 en=1111",
                         i, state, en);
            end
        end
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, LEFT}) begin
            nerr++;
            $display("FAIL restart_follow: got state=%0d en=%b, want state=2 en=1110", state, en);
        end
    endtask

    task automatic test_run_abort;
        run = 1'b0;
        tick();
        nvec++;
        if ({state, en} !== {S_IDLE, STOP}) begin
            nerr++;
            $display("FAIL abort_follow: got state=%0d en=%b, want state=0 en=1111", state, en);
        end
        run = 1'b1;
        repeat (4) tick();
        nvec++;
        if ({state, en} !== {S_START, STOP}) begin
            nerr++;
            $display("FAIL abort_setup: got state=%0d en=%b, want state=1 en=1111", state, en);
        end
        run = 1'b0;
        tick();
        nvec++;
        if ({state, en} !== {S_IDLE, STOP}) begin
            nerr++;
            $display("FAIL abort_start: got state=%0d en=%b, want state=0 en=1111", state, en);
        end
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if (state !== S_START) begin
                nerr++;
                $display("FAIL abort_redelay[%0d]: got state=%0d, want state=1", i, state);
            end
        end
        tick();
        nvec++;
        if ({state, en} !== {S_FOLLOW, LEFT}) begin
            nerr++;
            $display("FAIL abort_refollow: got state=%0d en=%b, want state=2 en=1110", state, en);
        end
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        din   = 4'b0000;
        test_reset();
        test_start_delay();
        test_steering();
        test_search_return();
        test_timeout_fault();
        test_finish();
        test_reset_midrun();
        test_run_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
